dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the cache-to-memory (dmem_*) request/ready interface.
//  Serves single-word read and byte-strobed write requests from the L1 data cache.
//  Requests arrive as one-cycle strobes; each completes with a one-cycle ready pulse after programmable wait states.
//  Holds one pending request while busy. Used as the backing store in SoC and in cache-level benches.
// PARAMETERS
//  ADDR_WIDTH  32    byte-address width
//  DATA_WIDTH  32    word width; multiple of 8
//  DEPTH       1024  words of storage; power of 2
//  LATENCY     2     wait states between acceptance and ready (0..15)
// PORTS
//  clk          in   1             clock
//  rst_n        in   1             reset, asynchronous, active-low
//  dmem_addr_i  in   ADDR_WIDTH    byte address, sampled with strobe
//  dmem_wdata_i in   DATA_WIDTH    write data, sampled with strobe
//  dmem_wstrb_i in   DATA_WIDTH/8  byte enables for write
//  dmem_write_i in   1             one-cycle write request strobe
//  dmem_read_i  in   1             one-cycle read request strobe
//  dmem_rdata_o out  DATA_WIDTH    read data; valid only while dmem_ready_o=1, else 0
//  dmem_ready_o out  1             one-cycle completion pulse (read or write)
//  overflow_o   out  1             sticky: a request was dropped
// BEHAVIOUR
//  - Word index = addr[$clog2(DEPTH)+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so addresses alias modulo DEPTH words.
//  - Request = read|write high in a cycle. If both are high, the request is a write.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    - IDLE: a strobe is accepted. addr, wdata, wstrb and op are captured. Wait counter loads LATENCY. Next state is BUSY.
//    - BUSY: counter decrements each cycle. At 0, the next state is RESP.
//    - RESP: dmem_ready_o=1 for exactly one cycle.
//  - Latency: strobe accepted in cycle T gives ready in cycle T+LATENCY+1. LATENCY=0 gives ready at T+1.
//  - Write commit: bytes with wstrb[i]=1 are written at the clock edge ending RESP. Other bytes are unchanged.
//  - Read: dmem_rdata_o = array[index] combinationally during RESP.
//  - Write-to-read ordering: a read accepted after a write's RESP cycle returns the new data.
//  - Pending slot (1-deep):
//    - A strobe arriving while not in IDLE goes into the empty pending slot.
//    - A strobe arriving in the RESP cycle is also pended.
//    - Strobe with slot full: request dropped, overflow_o=1 until reset.
//  - After RESP, a valid pending entry is accepted in the following cycle. That cycle counts as cycle T for the latency rule.
//  - Reset (any time, including mid-operation):
//    - FSM returns to IDLE; pending and in-flight requests are discarded; no write is committed.
//    - dmem_ready_o=0, dmem_rdata_o=0, overflow_o=0.
//    - Array contents are not reset.
//  - No other response signalling; every accepted request gets exactly one ready pulse.
// CONFIGURATION
//  DMEM_RESP_RANDLAT_EN defined:
//    - 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, advanced once per acceptance.
//    - Wait counter loads LATENCY + lfsr[1:0], i.e. LATENCY..LATENCY+3. Used to stress requester timing.
//  DMEM_RESP_RANDLAT_EN undefined: fixed LATENCY, no LFSR logic present.
// TESTING
//  (Defaults, macro undefined)
//  1. Assert rst_n=0 mid-BUSY of a write to 0x10 -> ready never pulses; all outputs 0; array[4] unchanged.
//  2. Write 0x10, 0xDEADBEEF, strb 4'hF at T -> ready at T+3. Read 0x10 at T+4 -> ready at T+7, rdata 0xDEADBEEF.
//  3. Write 0x10, 0x00001122, strb 4'b0011, then read 0x10 -> rdata 0xDEAD1122 (upper bytes preserved).
//  4. Write 0x20=0x5A5A5A5A at T, read 0x20 at T+1 (pended):
//     -> ready at T+3 for the write.
//     -> read accepted T+4, ready T+7 with rdata 0x5A5A5A5A.
//  5. Strobes at T, T+1, T+2 -> third is dropped; overflow_o=1 from T+3 and stays 1; exactly two ready pulses.
//  6. Write 0x1010=0x0BADF00D, then read 0x10 -> 0x0BADF00D (alias, DEPTH=1024).
//  7. read=write=1 with addr 0x30, wdata 0x12345678, strb 4'hF -> treated as write; later read 0x30 -> 0x12345678.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory backing store at the far end of the dmem_*
// request/ready interface. Accepts one-cycle read/write strobes, completes each
// with a one-cycle ready pulse after programmable wait states, and holds one
// pending request while busy. A strobe that finds the pending slot full is
// dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   dmem_addr_i    byte address (word index = addr[$clog2(DEPTH)+1:2])
//   dmem_wdata_i   write data
//   dmem_wstrb_i   byte enables for writes
//   dmem_write_i   write strobe (wins when read is also high)
//   dmem_read_i    read strobe
//   dmem_rdata_o   read data, zero unless dmem_ready_o is high
//   dmem_ready_o   one-cycle completion pulse
//   overflow_o     sticky dropped-request flag
//
// Optional feature: define DMEM_RESP_RANDLAT_EN to add 0..3 pseudo-random
// extra wait states per request (16-bit LFSR, taps 16,14,13,11).
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
  input  logic                    dmem_write_i,
  input  logic                    dmem_read_i,
  output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
  output logic                    dmem_ready_o,
  output logic                    overflow_o
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      cur_idx_q, cur_idx_d;
  logic [DATA_WIDTH-1:0] cur_data_q, cur_data_d;
  logic [STRB_W-1:0]     cur_strb_q, cur_strb_d;
  logic                  cur_wr_q, cur_wr_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [STRB_W-1:0]     pend_strb_q, pend_strb_d;
  logic                  pend_wr_q, pend_wr_d;
  logic                  ovf_q, ovf_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  req;
  logic [IDX_W-1:0]      req_idx;
  logic [4:0]            wait_ld;
  logic                  unused_addr_bits;

  assign req              = dmem_read_i | dmem_write_i;
  assign req_idx          = dmem_addr_i[IDX_W+1:2];
  assign unused_addr_bits = ^{dmem_addr_i[ADDR_WIDTH-1:IDX_W+2], dmem_addr_i[1:0]};

`ifdef DMEM_RESP_RANDLAT_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        accept;

  assign accept  = (state_q == S_IDLE) && (pend_vld_q || req);
  assign wait_ld = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign wait_ld = 5'(LATENCY);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_idx_d   = cur_idx_q;
    cur_data_d  = cur_data_q;
    cur_strb_d  = cur_strb_q;
    cur_wr_d    = cur_wr_q;
    pend_vld_d  = pend_vld_q;
    pend_idx_d  = pend_idx_q;
    pend_data_d = pend_data_q;
    pend_strb_d = pend_strb_q;
    pend_wr_d   = pend_wr_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        // The pending entry is older than any strobe arriving now, so it is
        // served first and the new strobe takes over the freed slot.
        if (pend_vld_q) begin
          cur_idx_d   = pend_idx_q;
          cur_data_d  = pend_data_q;
          cur_strb_d  = pend_strb_q;
          cur_wr_d    = pend_wr_q;
          state_d     = (wait_ld == 5'd0) ? S_RESP : S_BUSY;
          cnt_d       = wait_ld;
          pend_vld_d  = req;
          if (req) begin
            pend_idx_d  = req_idx;
            pend_data_d = dmem_wdata_i;
            pend_strb_d = dmem_wstrb_i;
            pend_wr_d   = dmem_write_i;
          end
        end else if (req) begin
          cur_idx_d  = req_idx;
          cur_data_d = dmem_wdata_i;
          cur_strb_d = dmem_wstrb_i;
          cur_wr_d   = dmem_write_i;
          state_d    = (wait_ld == 5'd0) ? S_RESP : S_BUSY;
          cnt_d      = wait_ld;
        end
      end
      // BUSY lasts exactly wait_ld cycles (wait_ld >= 1 on entry).
      S_BUSY: begin
        if (cnt_q <= 5'd1) state_d = S_RESP;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && req) begin
      if (pend_vld_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_vld_d  = 1'b1;
        pend_idx_d  = req_idx;
        pend_data_d = dmem_wdata_i;
        pend_strb_d = dmem_wstrb_i;
        pend_wr_d   = dmem_write_i;
      end
    end

    ready_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_idx_q   <= '0;
      cur_data_q  <= '0;
      cur_strb_q  <= '0;
      cur_wr_q    <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_idx_q  <= '0;
      pend_data_q <= '0;
      pend_strb_q <= '0;
      pend_wr_q   <= 1'b0;
      ovf_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_idx_q   <= cur_idx_d;
      cur_data_q  <= cur_data_d;
      cur_strb_q  <= cur_strb_d;
      cur_wr_q    <= cur_wr_d;
      pend_vld_q  <= pend_vld_d;
      pend_idx_q  <= pend_idx_d;
      pend_data_q <= pend_data_d;
      pend_strb_q <= pend_strb_d;
      pend_wr_q   <= pend_wr_d;
      ovf_q       <= ovf_d;
      ready_q     <= ready_d;
    end
  end

  // Storage is not reset; the commit is gated by state_q, which reset clears
  // asynchronously, so an interrupted write never lands.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && cur_wr_q) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (cur_strb_q[b]) mem_q[cur_idx_q][8*b +: 8] <= cur_data_q[8*b +: 8];
      end
    end
  end

  assign dmem_ready_o = ready_q;
  assign dmem_rdata_o = ready_q ? mem_q[cur_idx_q] : '0;
  assign overflow_o   = ovf_q;

endmodule
